// File: rtl/mem_pipe_ctrl.sv
// Single-port word memory with byte enables, post-reset zero sweep and an
// in-order, fixed-latency response pipeline (read data / write ack / error).
module mem_pipe_ctrl #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 24,
   parameter int ADDR_WIDTH = 5,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  wr_rd_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic [WIDTH/8-1:0]    be_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [WIDTH-1:0]      rd_data_o,
   output logic                  rd_valid_o,
   output logic                  wr_ack_o,
   output logic                  err_o
);

   localparam int NBYTES = WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   initCnt_q, initCnt_d;
   logic [WIDTH-1:0]        mem_q [DEPTH];

   logic                    accept;
   logic                    inRange;
   logic [WIDTH-1:0]        rdWord;

   logic [RD_LATENCY-1:0]   pValid_q, pWr_q, pErr_q;
   logic [WIDTH-1:0]        pData_q [RD_LATENCY];
   logic [RD_LATENCY-1:0]   inValid, inWr, inErr;
   logic [WIDTH-1:0]        inData [RD_LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         initCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         initCnt_q <= initCnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      initCnt_d = initCnt_q;
      case (state_q)
         INIT: begin
            if (initCnt_q == LAST_IDX) begin
               state_d = RUN;
            end else begin
               initCnt_d = initCnt_q + 1'b1;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Reset is also folded in combinationally so nothing is offered while it is held.
   assign ready_o = (state_q == RUN) && !rst;
   assign accept  = valid_i && ready_o;
   assign inRange = ({1'b0, addr_i} < DEPTH_EXT);
   assign rdWord  = inRange ? mem_q[addr_i] : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem_q[initCnt_q] <= '0;
         end else if (accept && wr_rd_i && inRange) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (be_i[b]) begin
                  mem_q[addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      inValid    = '0;
      inWr       = '0;
      inErr      = '0;
      inValid[0] = accept;
      inWr[0]    = wr_rd_i;
      inErr[0]   = !inRange;
      inData[0]  = rdWord;
      for (int i = 1; i < RD_LATENCY; i++) begin
         inValid[i] = pValid_q[i-1];
         inWr[i]    = pWr_q[i-1];
         inErr[i]   = pErr_q[i-1];
         inData[i]  = pData_q[i-1];
      end
   end

   // The final stage only captures read data so rd_data_o holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         pValid_q <= '0;
         pWr_q    <= '0;
         pErr_q   <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pData_q[i] <= '0;
         end
      end else begin
         pValid_q <= inValid;
         pWr_q    <= inWr;
         pErr_q   <= inErr;
         for (int i = 0; i < RD_LATENCY; i++) begin
            if ((i < RD_LATENCY - 1) || (inValid[i] && !inWr[i])) begin
               pData_q[i] <= inData[i];
            end
         end
      end
   end

   assign rd_valid_o = !rst && pValid_q[RD_LATENCY-1] && !pWr_q[RD_LATENCY-1];
   assign wr_ack_o   = !rst && pValid_q[RD_LATENCY-1] &&  pWr_q[RD_LATENCY-1];
   assign err_o      = !rst && pValid_q[RD_LATENCY-1] &&  pErr_q[RD_LATENCY-1];
   assign rd_data_o  = rst ? '0 : pData_q[RD_LATENCY-1];

endmodule

// File: doc/mem_pipe_ctrl.md
Name: mem_pipe_ctrl

Overview:
- Parametrised successor to the single-port valid/ready memory.
- Adds configurable width, depth and read latency, per-byte write enables, and an automatic zero-initialisation sweep after reset.
- Adds an in-order response pipeline that returns read data, write acknowledges and an out-of-range error flag.
- Sits behind the memory agent's interface; the bench drives it exactly as it drove the previous memory, plus the new response signals.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 24, number of implemented words; may be less than 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, address bus width.
- RD_LATENCY, 2, clock edges from accept edge to response; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr_i  in  ADDR_WIDTH  word address.
- wr_rd_i  in  1  1 = write, 0 = read.
- wr_data_i  in  WIDTH  write data.
- be_i  in  WIDTH/8  byte enables for writes; ignored on reads.
- valid_i  in  1  request valid.
- ready_o  out  1  controller can accept a request.
- rd_data_o  out  WIDTH  read response data.
- rd_valid_o  out  1  read response valid; 1-cycle pulse.
- wr_ack_o  out  1  write response valid; 1-cycle pulse.
- err_o  out  1  response error; qualified by rd_valid_o or wr_ack_o.

Behaviour:
- Reset: synchronous and active-high; sampled only on the clk rising edge.
- While rst=1:
  - FSM goes to INIT and the init counter is cleared to 0.
  - Response pipeline is flushed: all stage valids are 0.
  - ready_o=0, rd_valid_o=0, wr_ack_o=0, err_o=0, rd_data_o=0.
- Reset mid-operation has the same effect: in-flight responses are discarded and never emitted, and INIT restarts from word 0.
- FSM states:
  - INIT: writes 0 to word init_cnt each cycle and increments the counter. When init_cnt==DEPTH-1, the next state is RUN. ready_o=0 throughout.
  - RUN: ready_o=1 every cycle. There is no backpressure; the pipeline accepts one request per cycle.
- INIT lasts exactly DEPTH cycles after the first edge with rst=0. ready_o first rises in cycle DEPTH+1 after reset deassertion.
- Handshake: a request is accepted on a rising edge where valid_i=1 and ready_o=1. valid_i while ready_o=0 is ignored and never queued.
- Write accept with addr_i<DEPTH: for each i with be_i[i]=1, byte i of mem[addr_i] takes wr_data_i[8i+7:8i]. Bytes with be_i[i]=0 keep their value. be_i=0 is a legal no-op write and is still acknowledged.
- Out-of-range accept (addr_i>=DEPTH):
  - A write leaves memory unmodified.
  - A read returns rd_data_o=0.
  - The response carries err_o=1.
- Read data is the array content at the accept edge, including any write accepted on an earlier edge. Read-after-write to the same address on back-to-back cycles returns the new data.
- Response timing:
  - Every accepted request produces exactly one response.
  - The response is visible in the cycle following the edge RD_LATENCY-1 edges after the accept edge. RD_LATENCY=1 means it appears in the cycle right after acceptance.
  - rd_valid_o (read) or wr_ack_o (write) pulses for one cycle; they are never both high.
  - Responses are strictly in request order. A full pipeline holds RD_LATENCY responses.
- Outputs without a response: rd_data_o holds its last value; err_o=0.
- Arithmetic: no wrap-around on the address; the range check is a full ADDR_WIDTH compare. The init counter is ADDR_WIDTH wide and stops at DEPTH-1.

Test Plan:
- Init and reset:
  - Stimulus: hold rst=1 for 2 cycles, release, keep valid_i=1 with reads of addr 3.
  - Required: ready_o=0 for 24 cycles and no response pulses; first accept in cycle 25.
  - Required: rd_valid_o=1 two cycles later with rd_data_o=0x0000, err_o=0.
- Byte enables:
  - Stimulus: write 0xA5C3 to addr 7 with be=2'b11, then 0xFF00 to addr 7 with be=2'b01, then read addr 7.
  - Required: two wr_ack_o pulses, then rd_data_o=0xA500.
- Back-to-back streaming:
  - Stimulus: valid_i=1 for 10 consecutive cycles, alternating writes of data=addr*0x0101 and reads of the same address.
  - Required: 10 responses on 10 consecutive cycles in order; each read returns its address*0x0101; no gaps.
- Out of range:
  - Stimulus: write 0x1234 to addr 25, then read addr 25, then read addr 23.
  - Required: wr_ack_o with err_o=1; read of 25 gives rd_data_o=0, err_o=1; read of 23 gives 0x0000, err_o=0.
- Reset mid-flight:
  - Stimulus: accept reads at addr 1 and 2, then assert rst on the next edge.
  - Required: no rd_valid_o pulses follow; INIT repeats for 24 cycles; memory reads 0 everywhere afterwards.
- Latency sweep:
  - Stimulus: repeat the streaming test with RD_LATENCY=1 and with RD_LATENCY=4.
  - Required: response appears exactly 1 or 4 cycles after acceptance respectively; order and data are unchanged.
